// File: rtl/fml_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fml_mem_responder_pkg
//  Brief    : Shared types and constants for the COP memory responder model:
//             FSM encoding, captured-request layout, LFSR seed/taps and step.
//  Revision : 1.0  initial release
// ============================================================================
package fml_mem_responder_pkg;

  // Responder FSM encoding
  typedef enum logic [0:0] {
    FML_MEM_IDLE = 1'b0,
    FML_MEM_WAIT = 1'b1
  } fml_state_e;

  // Request fields held stable by the requester while it is stalled
  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  ben;
  } fml_req_t;

  // LFSR reset seed and tap mask for x^8 + x^6 + x^5 + x^4 + 1
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // One Fibonacci step: shift left, feedback is parity of the tapped bits
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fml_mem_responder_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module   : fml_mem_responder_lfsr8
//  Brief    : 8-bit Fibonacci LFSR used to draw pseudo-random stall cycles.
//             Advances only when step_i is high; async reset to the seed.
//  Revision : 1.0  initial release
// ============================================================================
module fml_mem_responder_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [7:0] state_o
);
  import fml_mem_responder_pkg::*;

  logic [7:0] state_q;

  // Advance the sequence on each accepted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= LFSR_SEED;
    end else if (step_i) begin
      state_q <= lfsr8_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule
`default_nettype wire

// File: rtl/fml_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : fml_mem_responder
//  Brief    : Verification-side memory model for the COP memory port. Holds a
//             word array, inserts fixed plus optional LFSR-driven stalls,
//             flags out-of-range accesses, detects requester protocol
//             violations and counts completed reads/writes.
//  Revision : 1.0  initial release
// ============================================================================
module fml_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          LATENCY    = 1,
  parameter int          RAND_STALL = 0
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  cop_mem_cen,
  input  logic                  cop_mem_wen,
  input  logic [31:0]           cop_mem_addr,
  input  logic [31:0]           cop_mem_wdata,
  input  logic [3:0]            cop_mem_ben,
  output logic [31:0]           cop_mem_rdata,
  output logic                  cop_mem_stall,
  output logic                  cop_mem_error,
  input  logic                  bd_wen,
  input  logic [DEPTH_LOG2-1:0] bd_addr,
  input  logic [31:0]           bd_wdata,
  output logic [15:0]           stat_reads,
  output logic [15:0]           stat_writes,
  output logic                  proto_err
);
  import fml_mem_responder_pkg::*;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  fml_state_e            state_q;
  logic [4:0]            cnt_q;
  fml_req_t              cap_q;
  logic [15:0]           reads_q;
  logic [15:0]           writes_q;
  logic                  proto_q;
  logic [31:0]           mem_q [DEPTH];

  logic [7:0]            lfsr;
  logic                  unused_lfsr;
  logic                  is_idle;
  logic [4:0]            wait_cycles;
  fml_req_t              live_req;
  fml_req_t              sel_req;
  logic                  resp;
  logic [31:0]           offset;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  bus_wr;

  fml_mem_responder_lfsr8 u_lfsr (
    .clk_i   (g_clk),
    .rst_i   (g_reset),
    .step_i  (is_idle && cop_mem_cen),
    .state_o (lfsr)
  );

  // Only the two low LFSR bits feed the stall draw
  assign unused_lfsr = ^lfsr[7:2];

  assign is_idle     = (state_q == FML_MEM_IDLE);
  assign wait_cycles = 5'(LATENCY) + ((RAND_STALL != 0) ? {3'b000, lfsr[1:0]} : 5'd0);
  assign live_req    = {cop_mem_wen, cop_mem_addr, cop_mem_wdata, cop_mem_ben};

  // In WAIT the captured request is authoritative even if the bus changed
  assign sel_req = is_idle ? live_req : cap_q;

  // Response and stall are combinational so a zero-wait access completes in
  // the request cycle; both are held low while reset is asserted
  assign resp          = !g_reset && cop_mem_cen &&
                         (is_idle ? (wait_cycles == 5'd0) : (cnt_q == 5'd0));
  assign cop_mem_stall = !g_reset && cop_mem_cen &&
                         (is_idle ? (wait_cycles != 5'd0) : (cnt_q != 5'd0));

  // Offset below BASE_ADDR wraps to a huge value and lands out of range
  assign offset   = sel_req.addr - BASE_ADDR;
  assign in_range = ((offset >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign idx      = offset[DEPTH_LOG2+1:2];
  assign bus_wr   = resp && in_range && sel_req.wen;

  assign cop_mem_rdata = (resp && in_range && !sel_req.wen) ? mem_q[idx] : 32'd0;
  assign cop_mem_error = resp && !in_range;
  assign stat_reads    = reads_q;
  assign stat_writes   = writes_q;
  assign proto_err     = proto_q;

  // Request FSM, protocol monitor and saturating traffic counters
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= FML_MEM_IDLE;
      cnt_q    <= 5'd0;
      cap_q    <= '0;
      reads_q  <= 16'd0;
      writes_q <= 16'd0;
      proto_q  <= 1'b0;
    end else begin
      case (state_q)
        FML_MEM_IDLE: begin
          if (cop_mem_cen && (wait_cycles != 5'd0)) begin
            state_q <= FML_MEM_WAIT;
            cnt_q   <= wait_cycles - 5'd1;
            cap_q   <= live_req;
          end
        end
        FML_MEM_WAIT: begin
          if (!cop_mem_cen) begin
            // Abandoned request: no write, no count
            proto_q <= 1'b1;
            state_q <= FML_MEM_IDLE;
          end else begin
            if (live_req != cap_q) begin
              proto_q <= 1'b1;
            end
            if (cnt_q == 5'd0) begin
              state_q <= FML_MEM_IDLE;
            end else begin
              cnt_q <= cnt_q - 5'd1;
            end
          end
        end
        default: state_q <= FML_MEM_IDLE;
      endcase

      if (resp) begin
        if (sel_req.wen) begin
          if (writes_q != 16'hFFFF) writes_q <= writes_q + 16'd1;
        end else begin
          if (reads_q != 16'hFFFF) reads_q <= reads_q + 16'd1;
        end
      end
    end
  end

  // Word array: backdoor first so a same-edge bus write to the word wins
  always_ff @(posedge g_clk) begin
    if (bd_wen) begin
      mem_q[bd_addr] <= bd_wdata;
    end
    if (bus_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_req.ben[b]) begin
          mem_q[idx][8*b +: 8] <= sel_req.wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fml_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fml_mem_responder
//  Brief    : Directed bench for fml_mem_responder. Four instances cover
//             zero latency, fixed latency, a small offset window and
//             LFSR-driven stalls; expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fml_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus and observation (0: LAT0, 1: LAT3, 2: window, 3: random)
  logic        rst   [4];
  logic        cen   [4];
  logic        wen   [4];
  logic [31:0] addr  [4];
  logic [31:0] wdata [4];
  logic [3:0]  ben   [4];
  logic        bdw   [4];
  logic [9:0]  bda   [4];
  logic [31:0] bdd   [4];
  logic [31:0] rdata [4];
  logic        stall [4];
  logic        err   [4];
  logic        perr  [4];
  logic [15:0] nrd   [4];
  logic [15:0] nwr   [4];

  int n_chk = 0;
  int n_err = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int          DL  = (g == 2) ? 4 : 10;
    localparam logic [31:0] BA  = (g == 2) ? 32'h1000 : 32'h0;
    localparam int          LAT = (g == 0) ? 0 : ((g == 1) ? 3 : 1);
    localparam int          RS  = (g == 3) ? 1 : 0;
    fml_mem_responder #(
      .DEPTH_LOG2 (DL),
      .BASE_ADDR  (BA),
      .LATENCY    (LAT),
      .RAND_STALL (RS)
    ) u_dut (
      .g_clk         (clk),
      .g_reset       (rst[g]),
      .cop_mem_cen   (cen[g]),
      .cop_mem_wen   (wen[g]),
      .cop_mem_addr  (addr[g]),
      .cop_mem_wdata (wdata[g]),
      .cop_mem_ben   (ben[g]),
      .cop_mem_rdata (rdata[g]),
      .cop_mem_stall (stall[g]),
      .cop_mem_error (err[g]),
      .bd_wen        (bdw[g]),
      .bd_addr       (bda[g][DL-1:0]),
      .bd_wdata      (bdd[g]),
      .stat_reads    (nrd[g]),
      .stat_writes   (nwr[g]),
      .proto_err     (perr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Backdoor word write; called and returns at posedge+1
  task automatic bd_write(input int u, input logic [9:0] i, input logic [31:0] d);
    bdw[u] = 1'b1; bda[u] = i; bdd[u] = d;
    @(posedge clk); #1;
    bdw[u] = 1'b0;
  endtask

  // Full bus access: counts stall cycles, samples the response cycle,
  // returns at posedge+1 after the response edge with cen dropped
  task automatic access(input int u, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be,
                        output int ns, output logic [31:0] rd, output logic er);
    cen[u] = 1'b1; wen[u] = w; addr[u] = a; wdata[u] = d; ben[u] = be;
    ns = 0;
    #1;
    while (stall[u] === 1'b1 && ns < 40) begin
      ns++;
      @(posedge clk); #2;
    end
    check("stall_bounded", {31'd0, stall[u]}, 32'd0);
    rd = rdata[u];
    er = err[u];
    @(posedge clk); #1;
    cen[u] = 1'b0; wen[u] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int          ns;
    logic [31:0] rd;
    logic        er;
    int          exp_ns [8];
    exp_ns = '{2, 3, 2, 3, 1, 2, 4, 4};

    for (int u = 0; u < 4; u++) begin
      rst[u] = 1'b1; cen[u] = 1'b0; wen[u] = 1'b0; addr[u] = 32'd0;
      wdata[u] = 32'd0; ben[u] = 4'd0; bdw[u] = 1'b0; bda[u] = 10'd0; bdd[u] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state; requests presented during reset must not respond or stall
    cen[1] = 1'b1;
    cen[0] = 1'b1; addr[0] = 32'h0001_0000;
    #1;
    check("rst_stall_gated", {31'd0, stall[1]}, 32'd0);
    check("rst_error_gated", {31'd0, err[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    cen[0] = 1'b0; cen[1] = 1'b0; addr[0] = 32'd0;
    for (int u = 0; u < 4; u++) begin
      check("rst_reads", {16'd0, nrd[u]}, 32'd0);
      check("rst_writes", {16'd0, nwr[u]}, 32'd0);
      check("rst_proto", {31'd0, perr[u]}, 32'd0);
    end
    @(posedge clk); #1;
    for (int u = 0; u < 4; u++) rst[u] = 1'b0;

    // Zero latency read of a preloaded word
    bd_write(0, 10'd3, 32'hDEADBEEF);
    access(0, 1'b0, 32'h0C, 32'd0, 4'h0, ns, rd, er);
    check("t1_stalls", ns, 0);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_error", {31'd0, er}, 32'd0);
    check("t1_reads", {16'd0, nrd[0]}, 32'd1);

    // Same-edge bus write and backdoor write to one word: bus data kept
    bdw[0] = 1'b1; bda[0] = 10'd5; bdd[0] = 32'h12345678;
    access(0, 1'b1, 32'h14, 32'hCAFEF00D, 4'hF, ns, rd, er);
    bdw[0] = 1'b0;
    access(0, 1'b0, 32'h14, 32'd0, 4'h0, ns, rd, er);
    check("t6_collision", rd, 32'hCAFEF00D);
    check("t6_writes", {16'd0, nwr[0]}, 32'd1);

    // Latency 3 partial write then read back
    bd_write(1, 10'd4, 32'h0);
    bd_write(1, 10'd6, 32'hAAAAAAAA);
    bd_write(1, 10'd7, 32'h77777777);
    access(1, 1'b1, 32'h10, 32'h11223344, 4'b0101, ns, rd, er);
    check("t2_wr_stalls", ns, 3);
    check("t2_wr_error", {31'd0, er}, 32'd0);
    access(1, 1'b0, 32'h10, 32'd0, 4'h0, ns, rd, er);
    check("t2_rd_stalls", ns, 3);
    check("t2_rdata", rd, 32'h00220044);

    // Requester drops cen after one stall cycle
    cen[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h18; wdata[1] = 32'h55555555; ben[1] = 4'hF;
    #1;
    check("t4_stall_first", {31'd0, stall[1]}, 32'd1);
    @(posedge clk); #1;
    cen[1] = 1'b0; wen[1] = 1'b0;
    @(posedge clk); #1;
    check("t4_proto", {31'd0, perr[1]}, 32'd1);
    check("t4_writes", {16'd0, nwr[1]}, 32'd1);
    check("t4_reads", {16'd0, nrd[1]}, 32'd1);
    access(1, 1'b0, 32'h18, 32'd0, 4'h0, ns, rd, er);
    check("t4_idle_stalls", ns, 3);
    check("t4_no_write", rd, 32'hAAAAAAAA);
    check("t4_reads_after", {16'd0, nrd[1]}, 32'd2);

    // Reset asserted mid-cycle during a stalled write
    cen[1] = 1'b1; wen[1] = 1'b1; addr[1] = 32'h1C; wdata[1] = 32'h0; ben[1] = 4'hF;
    @(posedge clk); #2;
    rst[1] = 1'b1;
    #1;
    check("t6_rst_stall", {31'd0, stall[1]}, 32'd0);
    check("t6_rst_reads", {16'd0, nrd[1]}, 32'd0);
    check("t6_rst_writes", {16'd0, nwr[1]}, 32'd0);
    check("t6_rst_proto", {31'd0, perr[1]}, 32'd0);
    @(posedge clk); #1;
    cen[1] = 1'b0; wen[1] = 1'b0; rst[1] = 1'b0;
    access(1, 1'b0, 32'h1C, 32'd0, 4'h0, ns, rd, er);
    check("t6_rst_stalls", ns, 3);
    check("t6_word_kept", rd, 32'h77777777);

    // Window 0x1000..0x103F: out-of-range both sides, no aliasing write
    bd_write(2, 10'd0, 32'h01010101);
    bd_write(2, 10'd15, 32'h0F0F0F0F);
    access(2, 1'b0, 32'h1040, 32'd0, 4'h0, ns, rd, er);
    check("t3_hi_error", {31'd0, er}, 32'd1);
    check("t3_hi_rdata", rd, 32'd0);
    check("t3_hi_stalls", ns, 1);
    access(2, 1'b0, 32'h0FFC, 32'd0, 4'h0, ns, rd, er);
    check("t3_lo_error", {31'd0, er}, 32'd1);
    check("t3_lo_rdata", rd, 32'd0);
    check("t3_reads", {16'd0, nrd[2]}, 32'd2);
    access(2, 1'b1, 32'h1040, 32'hFFFFFFFF, 4'hF, ns, rd, er);
    check("t3_wr_error", {31'd0, er}, 32'd1);
    check("t3_writes", {16'd0, nwr[2]}, 32'd1);
    access(2, 1'b0, 32'h1000, 32'd0, 4'h0, ns, rd, er);
    check("t3_word0", rd, 32'h01010101);
    check("t3_word0_error", {31'd0, er}, 32'd0);
    access(2, 1'b0, 32'h103C, 32'd0, 4'h0, ns, rd, er);
    check("t3_word15", rd, 32'h0F0F0F0F);

    // Address changed while stalled: captured address is served
    cen[2] = 1'b1; wen[2] = 1'b0; addr[2] = 32'h1000;
    @(posedge clk); #1;
    addr[2] = 32'h103C;
    #1;
    check("chg_stall", {31'd0, stall[2]}, 32'd0);
    check("chg_rdata", rdata[2], 32'h01010101);
    @(posedge clk); #1;
    cen[2] = 1'b0;
    check("chg_proto", {31'd0, perr[2]}, 32'd1);

    // Random stalls: W = 1 + lfsr[1:0] along A5,4A,95,2A,54,A9,53,A7
    for (int i = 0; i < 8; i++) bd_write(3, 10'(i), 32'hC0DE0000 + 32'(i));
    for (int i = 0; i < 8; i++) begin
      access(3, 1'b0, 32'(4 * i), 32'd0, 4'h0, ns, rd, er);
      check("t5_stalls", ns, exp_ns[i]);
      check("t5_rdata", rd, 32'hC0DE0000 + 32'(i));
    end
    check("t5_reads", {16'd0, nrd[3]}, 32'd8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
